// File: rtl/qracc_sram_responder.sv
// Responder end of the QRAcc SRAM request interface: sequences precharge,
// wordline and sense phases on the analog array and returns captured read data.
module qracc_sram_responder #(
    parameter int numRows   = 128,
    parameter int numCols   = 32,
    parameter int pchCycles = 1,
    parameter int wlCycles  = 2,
    parameter int saCycles  = 1,
    localparam int AW       = (numRows > 1) ? $clog2(numRows) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               rq_wr_i,
    input  logic               rq_valid_i,
    output logic               rq_ready_o,
    output logic               rd_valid_o,
    output logic [numCols-1:0] rd_data_o,
    input  logic [numCols-1:0] wr_data_i,
    input  logic [AW-1:0]      addr_i,
    input  logic               mac_busy_i,
    output logic [numRows-1:0] WL,
    output logic               PCH,
    output logic [numCols-1:0] WR_DATA,
    output logic               WRITE,
    output logic [numCols-1:0] CSEL,
    output logic               SAEN,
    input  logic [numCols-1:0] SA_OUT
);

    localparam int MAXC = (pchCycles > wlCycles)
                        ? ((pchCycles > saCycles) ? pchCycles : saCycles)
                        : ((wlCycles > saCycles) ? wlCycles : saCycles);
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [AW:0]          ROWS    = (AW+1)'(numRows);
    localparam logic [numRows-1:0]   WL_ONE  = {{(numRows-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]        PCH_LD  = CW'(pchCycles - 1);
    localparam logic [CW-1:0]        WL_LD   = CW'(wlCycles - 1);
    localparam logic [CW-1:0]        SA_LD   = CW'(saCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRECHARGE,
        WORDLINE,
        SENSE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [numCols-1:0] data_q, data_d;
    logic               idle_q, idle_d;
    logic               pch_q, pch_d;
    logic               saen_q, saen_d;
    logic               write_q, write_d;
    logic [numRows-1:0] wl_q, wl_d;
    logic [numCols-1:0] csel_q, csel_d;
    logic [numCols-1:0] wr_data_q, wr_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [numCols-1:0] rd_data_q, rd_data_d;
    logic               addr_ok_q, addr_ok_d;

    assign addr_ok_q = {1'b0, addr_q} < ROWS;
    assign addr_ok_d = {1'b0, addr_d} < ROWS;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (rq_valid_i && rq_ready_o) begin
                    wr_d    = rq_wr_i;
                    addr_d  = addr_i;
                    data_d  = wr_data_i;
                    state_d = PRECHARGE;
                    cnt_d   = PCH_LD;
                end
            end
            PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d = WORDLINE;
                    cnt_d   = WL_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WORDLINE: begin
                if (cnt_q == '0) begin
                    state_d = wr_q ? IDLE : SENSE;
                    cnt_d   = SA_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SENSE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin is a flop aligned with its phase.
    always_comb begin
        idle_d     = (state_d == IDLE);
        pch_d      = (state_d == PRECHARGE);
        saen_d     = (state_d == SENSE);
        wl_d       = '0;
        csel_d     = '0;
        write_d    = 1'b0;
        wr_data_d  = '0;
        if (state_d == WORDLINE) begin
            csel_d  = '1;
            if (addr_ok_d) begin
                wl_d = WL_ONE << addr_d;
            end
            write_d = wr_d && addr_ok_d;
            if (wr_d) begin
                wr_data_d = data_d;
            end
        end
        rd_valid_d = (state_q == SENSE) && (cnt_q == '0);
        rd_data_d  = rd_data_q;
        if (rd_valid_d) begin
            rd_data_d = addr_ok_q ? SA_OUT : '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            idle_q     <= 1'b0;
            pch_q      <= 1'b0;
            saen_q     <= 1'b0;
            write_q    <= 1'b0;
            wl_q       <= '0;
            csel_q     <= '0;
            wr_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idle_q     <= idle_d;
            pch_q      <= pch_d;
            saen_q     <= saen_d;
            write_q    <= write_d;
            wl_q       <= wl_d;
            csel_q     <= csel_d;
            wr_data_q  <= wr_data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Ready is the registered idle flag gated by the MAC so a busy array blocks acceptance at once.
    assign rq_ready_o = idle_q && !mac_busy_i;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign WL         = wl_q;
    assign PCH        = pch_q;
    assign WR_DATA    = wr_data_q;
    assign WRITE      = write_q;
    assign CSEL       = csel_q;
    assign SAEN       = saen_q;

endmodule

// File: tb/tb_qracc_sram_responder.sv
// Self-checking bench for qracc_sram_responder: a default instance and a
// 100-row / 3-1-2 instance, table-driven requests plus hand-written corner cases.
module tb_qracc_sram_responder;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rq_wr = 1'b0;
    logic        rq_valid0 = 1'b0;
    logic        rq_valid1 = 1'b0;
    logic [31:0] wdata = '0;
    logic [6:0]  addr = '0;
    logic        mac_busy = 1'b0;
    logic [31:0] sa_out = '0;

    logic         ready0, rdv0, pch0, write0, saen0;
    logic [31:0]  rdd0, wrd0, csel0;
    logic [127:0] wl0;
    logic         ready1, rdv1, pch1, write1, saen1;
    logic [31:0]  rdd1, wrd1, csel1;
    logic [99:0]  wl1;

    always #5 clk = ~clk;

    qracc_sram_responder dut0 (
        .clk(clk), .nrst(nrst), .rq_wr_i(rq_wr), .rq_valid_i(rq_valid0),
        .rq_ready_o(ready0), .rd_valid_o(rdv0), .rd_data_o(rdd0),
        .wr_data_i(wdata), .addr_i(addr), .mac_busy_i(mac_busy),
        .WL(wl0), .PCH(pch0), .WR_DATA(wrd0), .WRITE(write0),
        .CSEL(csel0), .SAEN(saen0), .SA_OUT(sa_out)
    );

    qracc_sram_responder #(
        .numRows(100), .numCols(32), .pchCycles(3), .wlCycles(1), .saCycles(2)
    ) dut1 (
        .clk(clk), .nrst(nrst), .rq_wr_i(rq_wr), .rq_valid_i(rq_valid1),
        .rq_ready_o(ready1), .rd_valid_o(rdv1), .rd_data_o(rdd1),
        .wr_data_i(wdata), .addr_i(addr), .mac_busy_i(mac_busy),
        .WL(wl1), .PCH(pch1), .WR_DATA(wrd1), .WRITE(write1),
        .CSEL(csel1), .SAEN(saen1), .SA_OUT(sa_out)
    );

    bit           sel = 1'b0;
    logic         m_ready, m_rdv, m_pch, m_write, m_saen;
    logic [31:0]  m_rdd, m_wrd, m_csel;
    logic [127:0] m_wl;

    always_comb begin
        m_ready = sel ? ready1 : ready0;
        m_rdv   = sel ? rdv1   : rdv0;
        m_pch   = sel ? pch1   : pch0;
        m_write = sel ? write1 : write0;
        m_saen  = sel ? saen1  : saen0;
        m_rdd   = sel ? rdd1   : rdd0;
        m_wrd   = sel ? wrd1   : wrd0;
        m_csel  = sel ? csel1  : csel0;
        m_wl    = sel ? {28'b0, wl1} : wl0;
    end

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;
    logic [31:0] sb[$];
    logic [31:0] hold0 = '0;
    logic [31:0] hold1 = '0;

    typedef struct {
        bit          sel;
        bit          wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [31:0] sa;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Read data scoreboard: every rd_valid pulse pops the oldest expected read.
    always @(negedge clk) begin
        if (nrst && (rdv0 || rdv1)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_rd_valid: got pulse, expected none at %0t", $time);
            end else begin
                check("rd_data", 128'(rdv0 ? rdd0 : rdd1), 128'(sb.pop_front()));
            end
        end
    end

    // Array safety: one of PCH / WL / SAEN at a time, WRITE only with a wordline.
    always @(negedge clk) begin
        if (nrst) begin
            if ((int'(pch0) + int'(|wl0) + int'(saen0)) > 1 || (write0 && !(|wl0))) begin
                viol++;
                $display("[TB] FAIL exclusion_dut0: pch=%b wl_any=%b saen=%b write=%b", pch0, |wl0, saen0, write0);
            end
            if ((int'(pch1) + int'(|wl1) + int'(saen1)) > 1 || (write1 && !(|wl1))) begin
                viol++;
                $display("[TB] FAIL exclusion_dut1: pch=%b wl_any=%b saen=%b write=%b", pch1, |wl1, saen1, write1);
            end
        end
    end

    task automatic applyStimulus(input bit s, input bit wr, input logic [6:0] a,
                                 input logic [31:0] d, output int waited);
        bit got;
        rq_wr = wr;
        addr  = a;
        wdata = d;
        if (s) rq_valid1 = 1'b1; else rq_valid0 = 1'b1;
        waited = 0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (m_ready) got = 1'b1; else waited++;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL handshake_timeout: got no ready, expected ready within 50 cycles");
            rq_valid0 = 1'b0;
            rq_valid1 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rq_valid0 = 1'b0;
        rq_valid1 = 1'b0;
        rq_wr = ~wr;
        addr  = ~a;
        wdata = ~d;
    endtask

    task automatic checkOutput(input vec_t v, output int waited);
        int p, w, s, rows, len;
        bit rd, ok, in_p, in_w, in_s;
        logic [127:0] one = 128'd1;
        sel  = v.sel;
        p    = v.sel ? 3 : 1;
        w    = v.sel ? 1 : 2;
        s    = v.sel ? 2 : 1;
        rows = v.sel ? 100 : 128;
        rd   = !v.wr;
        ok   = int'(v.addr) < rows;
        if (rd) begin
            sb.push_back(v.exp_rd);
        end
        applyStimulus(v.sel, v.wr, v.addr, v.data, waited);
        len = rd ? p + w + s + 1 : p + w + 1;
        for (int k = 1; k <= len; k++) begin
            in_p = (k <= p);
            in_w = (k > p) && (k <= p + w);
            in_s = rd && (k > p + w) && (k <= p + w + s);
            sa_out = in_s ? v.sa : ~v.sa;
            @(negedge clk);
            check("wl", m_wl, (in_w && ok) ? (one << v.addr) : 128'd0);
            check("ctrl{pch,saen,write,ready,rdv}",
                  128'({m_pch, m_saen, m_write, m_ready, m_rdv}),
                  128'({in_p, in_s, in_w && v.wr && ok, k == len, rd && k == len}));
            check("csel", 128'(m_csel), in_w ? 128'hFFFF_FFFF : 128'd0);
            check("wr_data", 128'(m_wrd), (in_w && v.wr) ? 128'(v.data) : 128'd0);
            @(posedge clk);
            #1;
        end
        if (rd) begin
            if (v.sel) hold1 = v.exp_rd; else hold0 = v.exp_rd;
        end else begin
            check("rd_data_hold", 128'(m_rdd), 128'(v.sel ? hold1 : hold0));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int waited;
        vec_t v;
        logic [127:0] one = 128'd1;

        vecs[0]  = '{1'b0, 1'b1, 7'd5,   32'hA5A5_5A5A, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 1'b0, 7'd5,   32'h0,         32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[2]  = '{1'b0, 1'b1, 7'd7,   32'hDEAD_BEEF, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 1'b0, 7'd0,   32'h0,         32'h1234_5678, 32'h1234_5678};
        vecs[4]  = '{1'b0, 1'b0, 7'd127, 32'h0,         32'hFFFF_0000, 32'hFFFF_0000};
        vecs[5]  = '{1'b0, 1'b1, 7'd127, 32'h0000_0001, 32'h0,         32'h0};
        vecs[6]  = '{1'b0, 1'b0, 7'd64,  32'h0,         32'h0,         32'h0};
        vecs[7]  = '{1'b1, 1'b0, 7'd110, 32'h0,         32'hCAFE_F00D, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 7'd99,  32'h0,         32'h1357_9BDF, 32'h1357_9BDF};
        vecs[9]  = '{1'b1, 1'b1, 7'd110, 32'h0000_00FF, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 1'b1, 7'd0,   32'h8000_0001, 32'h0,         32'h0};

        #3;
        check("reset_ctrl0", 128'({ready0, rdv0, pch0, write0, saen0}), 128'd0);
        check("reset_wl0", wl0, 128'd0);
        check("reset_buses0", 128'({rdd0, wrd0, csel0}), 128'd0);
        check("reset_ready1", 128'(ready1), 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset0", 128'(ready0), 128'd1);
        check("ready_after_reset1", 128'(ready1), 128'd1);

        for (int i = 0; i < 11; i++) begin
            checkOutput(vecs[i], waited);
        end

        // Back-to-back reads with valid held: second handshake lands in the rd_valid cycle.
        sel = 1'b0;
        sb.push_back(32'h1111_2222);
        sb.push_back(32'h3333_4444);
        rq_wr = 1'b0;
        addr = 7'd0;
        rq_valid0 = 1'b1;
        waited = 0;
        while (!ready0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        addr = 7'd127;
        for (int k = 1; k <= 5; k++) begin
            sa_out = (k == 4) ? 32'h1111_2222 : 32'hEEEE_DDDD;
            @(negedge clk);
            check("b2b_wl_first", wl0, (k == 2 || k == 3) ? one : 128'd0);
            check("b2b_ready_rdv_first", 128'({ready0, rdv0}), (k == 5) ? 128'd3 : 128'd0);
            @(posedge clk);
            #1;
        end
        rq_valid0 = 1'b0;
        addr = 7'd0;
        for (int k = 1; k <= 5; k++) begin
            sa_out = (k == 4) ? 32'h3333_4444 : 32'hCCCC_BBBB;
            @(negedge clk);
            check("b2b_wl_second", wl0, (k == 2 || k == 3) ? (one << 127) : 128'd0);
            check("b2b_pch_second", 128'(pch0), (k == 1) ? 128'd1 : 128'd0);
            check("b2b_ready_rdv_second", 128'({ready0, rdv0}), (k == 5) ? 128'd3 : 128'd0);
            @(posedge clk);
            #1;
        end
        hold0 = 32'h3333_4444;

        // MAC busy blocks acceptance; clearing it lets the request in at the next edge.
        mac_busy = 1'b1;
        rq_valid0 = 1'b1;
        rq_wr = 1'b0;
        addr = 7'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("busy_quiet", 128'({ready0, pch0, |wl0, saen0, rdv0}), 128'd0);
            @(posedge clk);
            #1;
        end
        mac_busy = 1'b0;
        rq_valid0 = 1'b0;
        v = '{1'b0, 1'b0, 7'd3, 32'h0, 32'h0F0F_1234, 32'h0F0F_1234};
        checkOutput(v, waited);
        check("busy_release_wait", 128'(waited), 128'd0);

        // Reset in the middle of a read's wordline phase drops the request.
        sel = 1'b0;
        applyStimulus(1'b0, 1'b0, 7'd9, 32'h0, waited);
        sa_out = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_reset_wl", wl0, one << 9);
        #2;
        nrst = 1'b0;
        #1;
        check("abort_ctrl", 128'({ready0, rdv0, pch0, write0, saen0}), 128'd0);
        check("abort_wl", wl0, 128'd0);
        check("abort_buses", 128'({rdd0, csel0}), 128'd0);
        hold0 = '0;
        hold1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_abort", 128'(ready0), 128'd1);
        repeat (8) @(posedge clk);
        #1;
        v = '{1'b0, 1'b0, 7'd9, 32'h0, 32'h600D_0009, 32'h600D_0009};
        checkOutput(v, waited);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        check("exclusion_violations", 128'(viol), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
